// File: rtl/inst_fetch_if.sv
// inst_fetch_if: PC/fetch-enable request, RAM byte port and IF/ID result
// bundle; master is the PC/RAM side, slave is the fetch unit.
interface inst_fetch_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] pc_in;
    logic              ce_in;
    logic              branch_flag_in;
    logic [7:0]        mem_din_in;
    logic [ADDR_W-1:0] mem_a_out;
    logic              mem_wr_out;
    logic [31:0]       inst_out;
    logic [ADDR_W-1:0] inst_addr_out;
    logic              inst_valid_out;
    logic              stall_req_out;

    modport master (
        output pc_in,
        output ce_in,
        output branch_flag_in,
        output mem_din_in,
        input  mem_a_out,
        input  mem_wr_out,
        input  inst_out,
        input  inst_addr_out,
        input  inst_valid_out,
        input  stall_req_out
    );

    modport slave (
        input  pc_in,
        input  ce_in,
        input  branch_flag_in,
        input  mem_din_in,
        output mem_a_out,
        output mem_wr_out,
        output inst_out,
        output inst_addr_out,
        output inst_valid_out,
        output stall_req_out
    );
endinterface

// File: rtl/inst_fetch.sv
// inst_fetch: reads a 32-bit little-endian instruction over a byte RAM port.
// Define ICACHE_EN to add a direct-mapped instruction cache.
module inst_fetch #(
    parameter int ADDR_W         = 32,
    parameter int ICACHE_INDEX_W = 4
) (
    input logic         clk_in,
    input logic         rst_in,
    input logic         rdy_in,
    inst_fetch_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t            state;
    state_t            state_nx;
    logic [1:0]        cyc;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] mem_a;
    logic [ADDR_W-1:0] inst_addr;
    logic [23:0]       lo;
    logic [31:0]       inst;
    logic              valid;
    logic              stall;
    logic              start;
    logic              hit;
    logic              step;
    logic              flush;
    logic              finish;
    logic [31:0]       hit_inst;

    if (ICACHE_INDEX_W < 1 || ICACHE_INDEX_W > ADDR_W - 3) begin : g_bad_cfg
        $error("ICACHE_INDEX_W out of range for ADDR_W");
    end

`ifdef ICACHE_EN
    localparam int ENTRIES = 1 << ICACHE_INDEX_W;
    localparam int TAG_W   = ADDR_W - ICACHE_INDEX_W - 2;

    logic [ENTRIES-1:0]        c_valid;
    logic [TAG_W-1:0]          c_tag  [ENTRIES];
    logic [31:0]               c_data [ENTRIES];
    logic [ICACHE_INDEX_W-1:0] rd_idx;
    logic [ICACHE_INDEX_W-1:0] wr_idx;
    logic                      fill;

    assign rd_idx   = bus.pc_in[ICACHE_INDEX_W+1:2];
    assign wr_idx   = base[ICACHE_INDEX_W+1:2];
    assign hit_inst = c_data[rd_idx];
    assign fill     = rdy_in && finish && base[1:0] == 2'b00;

    always_comb begin
        hit = 1'b0;
        if (state == IDLE && bus.ce_in && !bus.branch_flag_in
            && bus.pc_in[1:0] == 2'b00 && c_valid[rd_idx]
            && c_tag[rd_idx] == bus.pc_in[ADDR_W-1:ICACHE_INDEX_W+2])
            hit = 1'b1;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in)
            c_valid <= '0;
        else if (fill)
            c_valid[wr_idx] <= 1'b1;
    end

    // Tag/data arrays need no reset; the valid bits guard them.
    always_ff @(posedge clk_in) begin
        if (!rst_in && fill) begin
            c_tag[wr_idx]  <= base[ADDR_W-1:ICACHE_INDEX_W+2];
            c_data[wr_idx] <= {bus.mem_din_in, lo};
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_inst = '0;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in)
            state <= IDLE;
        else if (rdy_in)
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = ADDR;
            ADDR: begin
                if (bus.branch_flag_in)
                    state_nx = IDLE;
                else if (cyc == 2'd3)
                    state_nx = DATA;
            end
            DATA:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        flush  = bus.branch_flag_in && state != IDLE;
        start  = state == IDLE && bus.ce_in
                 && !bus.branch_flag_in && !hit;
        step   = state == ADDR && !bus.branch_flag_in;
        finish = state == DATA && !bus.branch_flag_in;
    end

    // Byte k arrives while cyc == k+1; byte 3 arrives in DATA.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            base      <= '0;
            mem_a     <= '0;
            inst      <= '0;
            inst_addr <= '0;
            lo        <= '0;
            cyc       <= '0;
            valid     <= 1'b0;
            stall     <= 1'b0;
        end else if (rdy_in) begin
            valid <= 1'b0;
            if (start) begin
                base  <= bus.pc_in;
                mem_a <= bus.pc_in;
                stall <= 1'b1;
                cyc   <= '0;
            end
            if (hit) begin
                inst      <= hit_inst;
                inst_addr <= bus.pc_in;
                valid     <= 1'b1;
            end
            if (step) begin
                cyc <= cyc + 2'd1;
                if (cyc != 2'd3)
                    mem_a <= mem_a + ADDR_W'(1);
                if (cyc != 2'd0)
                    lo <= {bus.mem_din_in, lo[23:8]};
            end
            if (flush)
                stall <= 1'b0;
            if (finish) begin
                inst      <= {bus.mem_din_in, lo};
                inst_addr <= base;
                valid     <= 1'b1;
                stall     <= 1'b0;
            end
        end
    end

    assign bus.mem_a_out      = mem_a;
    assign bus.mem_wr_out     = 1'b0;
    assign bus.inst_out       = inst;
    assign bus.inst_addr_out  = inst_addr;
    assign bus.inst_valid_out = valid;
    assign bus.stall_req_out  = stall;
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed fetch scenarios for inst_fetch, checked every
// cycle against a request-timeline model plus hand-computed literals.
module tb_inst_fetch;
    localparam int AW   = 32;
    localparam int NONE = 99;
    localparam int NC   = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;
    int   total = 0;
    int   bad = 0;
    bit   chk_on = 1'b0;

    inst_fetch_if #(.ADDR_W(AW)) bus ();

    inst_fetch #(
        .ADDR_W(AW),
        .ICACHE_INDEX_W(4)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .rdy_in(rdy),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] ram_b(input logic [AW-1:0] a);
        case (a)
            32'd0:   return 8'h13;
            32'd1:   return 8'h05;
            32'd2:   return 8'h10;
            32'd3:   return 8'h00;
            default: return (a[7:0] ^ 8'hA5) + a[15:8];
        endcase
    endfunction

    function automatic logic [31:0] word_at(input logic [AW-1:0] a);
        return {ram_b(a + 3), ram_b(a + 2), ram_b(a + 1), ram_b(a)};
    endfunction

    // RAM answers one cycle after the address and stalls with rdy.
    always @(posedge clk)
        if (rdy) bus.mem_din_in <= ram_b(bus.mem_a_out);

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: e = cycles since the request was accepted.
    logic [AW-1:0] m_a, m_iaddr, m_pc;
    logic [31:0]   m_inst;
    logic          m_valid, m_stall, m_busy;
    int            m_e;
`ifdef ICACHE_EN
    logic          m_cv    [16];
    logic [AW-1:0] m_cpc   [16];
    logic [31:0]   m_cinst [16];
`endif

    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_a = '0; m_iaddr = '0; m_pc = '0; m_inst = '0;
            m_valid = 0; m_stall = 0; m_busy = 0; m_e = 0;
`ifdef ICACHE_EN
            for (int i = 0; i < 16; i++) m_cv[i] = 0;
`endif
        end else if (rdy) begin
            m_valid = 0;
            if (m_busy) begin
                if (bus.branch_flag_in) begin
                    m_busy = 0;
                    m_stall = 0;
                end else begin
                    m_e++;
                    if (m_e <= 4) m_a = m_pc + AW'(m_e - 1);
                    if (m_e == 6) begin
                        m_busy = 0;
                        m_stall = 0;
                        m_valid = 1;
                        m_inst = word_at(m_pc);
                        m_iaddr = m_pc;
`ifdef ICACHE_EN
                        if (m_pc[1:0] == 2'b00) begin
                            m_cv[m_pc[5:2]] = 1;
                            m_cpc[m_pc[5:2]] = m_pc;
                            m_cinst[m_pc[5:2]] = m_inst;
                        end
`endif
                    end
                end
            end else if (bus.ce_in && !bus.branch_flag_in) begin
`ifdef ICACHE_EN
                if (bus.pc_in[1:0] == 2'b00 && m_cv[bus.pc_in[5:2]]
                    && m_cpc[bus.pc_in[5:2]] == bus.pc_in) begin
                    m_valid = 1;
                    m_inst = m_cinst[bus.pc_in[5:2]];
                    m_iaddr = bus.pc_in;
                end else begin
`else
                begin
`endif
                    m_busy = 1;
                    m_e = 1;
                    m_pc = bus.pc_in;
                    m_a = bus.pc_in;
                    m_stall = 1;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            check("mem_a", bus.mem_a_out, m_a);
            check("mem_wr", bus.mem_wr_out, 0);
            check("stall", bus.stall_req_out, m_stall);
            check("valid", bus.inst_valid_out, m_valid);
            check("inst", bus.inst_out, m_inst);
            check("inst_addr", bus.inst_addr_out, m_iaddr);
        end
    end

    logic [AW-1:0] rec_a [0:NC];
    logic          rec_s [0:NC];
    int            v1, v2;
    logic [31:0]   i1;
    logic [AW-1:0] a1, a2;

    task automatic do_reset();
        rst = 1; rdy = 0;
        bus.ce_in = 0; bus.branch_flag_in = 0; bus.pc_in = '0;
        repeat (2) @(negedge clk);
        chk_on = 1;
        check("rst_mem_a", bus.mem_a_out, 0);
        check("rst_inst", bus.inst_out, 0);
        check("rst_addr", bus.inst_addr_out, 0);
        check("rst_valid", bus.inst_valid_out, 0);
        check("rst_stall", bus.stall_req_out, 0);
        rst = 0; rdy = 1;
    endtask

    // Request issued now (cycle 0); n counts cycles after it.
    task automatic run_fetch(input logic [AW-1:0] pc,
                             input int flush_at,
                             input int stall_at, input int stall_len,
                             input int r2_from, input int r2_to,
                             input logic [AW-1:0] pc2);
        v1 = 0; v2 = 0;
        bus.pc_in = pc;
        bus.ce_in = 1;
        bus.branch_flag_in = (flush_at == 0);
        for (int n = 1; n <= NC; n++) begin
            @(negedge clk);
            rec_a[n] = bus.mem_a_out;
            rec_s[n] = bus.stall_req_out;
            if (bus.inst_valid_out) begin
                if (v1 == 0) begin
                    v1 = n; i1 = bus.inst_out; a1 = bus.inst_addr_out;
                end else if (v2 == 0) begin
                    v2 = n; a2 = bus.inst_addr_out;
                end
            end
            bus.ce_in = (n >= r2_from && n <= r2_to);
            if (n >= r2_from) bus.pc_in = pc2;
            bus.branch_flag_in = (n == flush_at);
            rdy = !(n >= stall_at && n < stall_at + stall_len);
        end
        bus.ce_in = 0; bus.branch_flag_in = 0; rdy = 1;
    endtask

    initial begin
        int nv;
        do_reset();
        run_fetch(0, NONE, NONE, 0, NONE, 0, 0);
        for (int k = 1; k <= 4; k++) check("t1_addr", rec_a[k], k - 1);
        for (int k = 1; k <= 5; k++) check("t1_stall", rec_s[k], 1);
        check("t1_stall6", rec_s[6], 0);
        check("t1_vcyc", v1, 6);
        check("t1_inst", i1, 32'h00100513);
        check("t1_iaddr", a1, 0);

        do_reset();
        run_fetch(0, NONE, NONE, 0, 1, 6, 32'h4);
        check("b2b_v1", v1, 6);
        check("b2b_v2", v2, 12);
        check("b2b_addr2", a2, 32'h4);

        do_reset();
        run_fetch(32'h8, 3, NONE, 0, 4, 4, 32'h100);
        check("fl_stall3", rec_s[3], 1);
        check("fl_stall4", rec_s[4], 0);
        check("fl_vcyc", v1, 10);
        check("fl_addr", a1, 32'h100);

        do_reset();
        run_fetch(32'h20, 5, NONE, 0, NONE, 0, 0);
        check("fl5_novalid", v1, 0);

        run_fetch(32'h24, 0, NONE, 0, NONE, 0, 0);
        check("flidle_novalid", v1, 0);
        check("flidle_stall", rec_s[1], 0);

        do_reset();
        run_fetch(0, NONE, 2, 3, NONE, 0, 0);
        for (int k = 2; k <= 5; k++) check("rdy_addr", rec_a[k], 1);
        check("rdy_vcyc", v1, 9);
        check("rdy_inst", i1, 32'h00100513);

        do_reset();
        run_fetch(32'hFFFFFFFE, NONE, NONE, 0, NONE, 0, 0);
        check("wrap_a1", rec_a[1], 32'hFFFFFFFE);
        check("wrap_a2", rec_a[2], 32'hFFFFFFFF);
        check("wrap_a3", rec_a[3], 32'h00000000);
        check("wrap_a4", rec_a[4], 32'h00000001);
        check("wrap_vcyc", v1, 6);
        check("wrap_iaddr", a1, 32'hFFFFFFFE);

        do_reset();
        bus.pc_in = 32'hC; bus.ce_in = 1;
        @(negedge clk);
        bus.ce_in = 0;
        repeat (2) @(negedge clk);
        rst = 1;
        @(negedge clk);
        check("midrst_stall", bus.stall_req_out, 0);
        check("midrst_mem_a", bus.mem_a_out, 0);
        rst = 0;
        nv = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.inst_valid_out) nv++;
        end
        check("midrst_novalid", nv, 0);

`ifdef ICACHE_EN
        do_reset();
        run_fetch(32'h40, NONE, NONE, 0, NONE, 0, 0);
        check("ic_miss1", v1, 6);
        run_fetch(32'h40, NONE, NONE, 0, NONE, 0, 0);
        check("ic_hit", v1, 1);
        for (int k = 1; k <= 6; k++) check("ic_hit_stall", rec_s[k], 0);
        run_fetch(32'h440, NONE, NONE, 0, NONE, 0, 0);
        check("ic_conflict", v1, 6);
        run_fetch(32'h40, NONE, NONE, 0, NONE, 0, 0);
        check("ic_evicted", v1, 6);
`endif

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Consumer end of the PC/fetch-enable interface. It takes the program counter and chip-enable from the PC register and reads a 32-bit instruction over the byte-wide RAM port.
- It assembles the four bytes little-endian and hands the instruction to IF/ID with a one-cycle valid pulse.
- It raises a stall request while a fetch is outstanding, so the PC register and upstream stages hold.

Parameters:
- ADDR_W, 32, width of pc_in and mem_a_out.
- ICACHE_INDEX_W, 4, log2 of I-cache entries. Used only with ICACHE_EN.

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  synchronous reset, active-high.
- rdy_in  input  1  global ready; low freezes all state.
- pc_in  input  ADDR_W  fetch address from the PC register.
- ce_in  input  1  fetch request (chip enable) from the PC register.
- branch_flag_in  input  1  flush; abort any in-flight fetch.
- mem_din_in  input  8  RAM read data; valid one cycle after its address.
- mem_a_out  output  ADDR_W  RAM byte address (registered).
- mem_wr_out  output  1  RAM write enable; constant 0.
- inst_out  output  32  fetched instruction.
- inst_addr_out  output  ADDR_W  pc of inst_out.
- inst_valid_out  output  1  one-cycle pulse; inst_out is valid.
- stall_req_out  output  1  high while a fetch is outstanding.

Behaviour:
- Reset (rst_in=1 at an edge):
  - state=IDLE.
  - mem_a_out=0, inst_out=0, inst_addr_out=0.
  - inst_valid_out=0, stall_req_out=0, mem_wr_out=0.
  - Reset overrides rdy_in.
  - Reset mid-fetch abandons the fetch with no valid pulse.
- rdy_in=0 with rst_in=0: every register holds, including FSM, byte counter, outputs and cache. RAM is stalled by the same rdy, so the sequence resumes unchanged.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If ce_in=1 (and no hit under ICACHE_EN), latch pc_in as base and go to ADDR.
  - Set mem_a_out<=base, stall_req_out<=1.
  - ce_in=0: remain in IDLE.
- Address/data timing, for a request in cycle t:
  - mem_a_out = base, base+1, base+2, base+3 in cycles t+1..t+4.
  - Byte k is sampled from mem_din_in at the end of cycle t+2+k into inst_out[8k+7:8k].
  - After the last address the FSM waits in DATA for byte 3.
- Completion:
  - inst_out/inst_addr_out are updated at the end of cycle t+5.
  - inst_valid_out=1 during cycle t+6 only.
  - stall_req_out is high cycles t+1..t+5 and low in t+6.
  - Latency: 6 cycles from request to valid.
- Back-to-back: a request seen in the valid cycle (state IDLE) is accepted. Peak throughput is one instruction per 6 cycles.
- ce_in during a fetch: ignored (upstream is stalled).
- Address arithmetic: base+k is modulo 2^ADDR_W (wraps at the top). No alignment check; a misaligned pc fetches bytes pc..pc+3 exactly.
- Flush (branch_flag_in=1 in any non-IDLE cycle):
  - Next state is IDLE; stall_req_out<=0.
  - No valid pulse; late bytes are discarded.
  - Flush together with final byte capture: flush wins, no valid.
  - Flush in IDLE with ce_in=1 the same cycle: the request is ignored that cycle.
- inst_out keeps its last value when inst_valid_out=0.

Optional Feature:
- Macro: ICACHE_EN.
- Defined:
  - Direct-mapped I-cache of 2^ICACHE_INDEX_W entries, each holding valid, tag and 32-bit instruction.
  - Index = pc[ICACHE_INDEX_W+1:2]; tag = pc[ADDR_W-1:ICACHE_INDEX_W+2]. Hits require pc[1:0]=0.
  - Hit in IDLE (ce_in=1, entry valid, tag match, no flush): inst_out/inst_addr_out registered, inst_valid_out=1 in cycle t+1. No memory access; stall_req_out stays 0.
  - A miss runs the normal fetch. On completion with no flush, an aligned miss fills its entry.
  - Reset clears all valid bits.
- Not defined: no cache storage; every request uses the 6-cycle memory path.

Test Plan:
- Reset then ce_in=1, pc_in=0x0, RAM[0..3]=13,05,10,00:
  - mem_a_out=0,1,2,3 in cycles 1-4.
  - inst_valid_out=1 in cycle 6 with inst_out=0x00100513, inst_addr_out=0.
  - stall_req_out high in cycles 1-5.
- Back-to-back: ce_in held high with pc 0x0 then 0x4 → valid pulses in cycles 6 and 12; second inst_addr_out=0x4.
- Flush: request pc=0x8, branch_flag_in=1 in cycle 3 → no valid pulse, stall_req_out=0 from cycle 4. A new request at pc=0x100 in cycle 4 yields valid in cycle 10.
- Flush coinciding with byte-3 capture (cycle 5) → no valid pulse in cycle 6.
- rdy_in=0 for 3 cycles starting in cycle 2 of a fetch:
  - mem_a_out holds at 0x1 during the stall.
  - The valid pulse arrives 3 cycles late with the correct data.
- Wrap: ADDR_W=32, pc_in=0xFFFFFFFE → mem_a_out=FFFFFFFE, FFFFFFFF, 00000000, 00000001.
- ICACHE_EN: fetch pc=0x40, then re-request 0x40 → second valid in cycle t+1, stall_req_out never high. Fetching 0x440 (same index, different tag) misses; a later 0x40 misses again.
